// File: rtl/fifo_word_packer.sv
// fifo_word_packer: drains an 8-bit FIFO (fifo_data/fifo_empty/fifo_rd) into little-endian BYTES-wide words on m_data/m_keep/m_last/m_valid/m_ready, with flush/idle-timeout partial words and a busy flag
module fifo_word_packer #(
  parameter int BYTES        = 4,
  parameter int IDLE_TIMEOUT = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         fifo_data,
  input  logic               fifo_empty,
  output logic               fifo_rd,
  input  logic               flush,
  output logic [8*BYTES-1:0] m_data,
  output logic [BYTES-1:0]   m_keep,
  output logic               m_last,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               busy
);
  localparam int IW = $clog2(BYTES);
  localparam int TO = IDLE_TIMEOUT > 0 ? IDLE_TIMEOUT : 1;
  localparam int CW = $clog2(TO + 1);
  localparam logic [IW-1:0] LAST_LANE = IW'(BYTES - 1);
  localparam logic [CW-1:0] CNT_HIT = CW'(TO - 1);
  localparam logic TO_EN = IDLE_TIMEOUT > 0;
  typedef enum logic {FILL, HOLD} state_t;
  state_t state, state_nx;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;
  logic flush_pend, fill, rd_ok, timeout_hit, do_flush, has_bytes;
  logic [BYTES-1:0] part_keep;
  assign fill        = state == FILL;
  assign has_bytes   = idx != '0;
  assign rd_ok       = fill & ~fifo_empty & ~flush & ~flush_pend & ~rst;
  assign timeout_hit = TO_EN & fill & has_bytes & ~rd_ok & (cnt == CNT_HIT);
  assign do_flush    = fill & (flush | flush_pend | timeout_hit);
  always_comb begin
    part_keep = '0;
    for (int i = 0; i < BYTES; i++) part_keep[i] = i < int'(idx);
  end
  always_ff @(posedge clk) state <= rst ? FILL : state_nx;
  always_comb
    state_nx = fill ? (((fifo_rd & (idx == LAST_LANE)) | (do_flush & has_bytes)) ? HOLD : FILL)
                    : (m_ready ? FILL : HOLD);
  always_comb begin
    fifo_rd = rd_ok & ~timeout_hit;
    m_valid = ~fill;
    busy    = has_bytes | ~fill;
  end
  always_ff @(posedge clk)
    if (rst) begin
      idx        <= '0;
      cnt        <= '0;
      flush_pend <= 1'b0;
      m_data     <= '0;
      m_keep     <= '0;
      m_last     <= 1'b0;
    end else begin
      flush_pend <= fill ? 1'b0 : flush_pend | flush;
      cnt        <= (fifo_rd | ~fill | do_flush | ~TO_EN) ? '0 : has_bytes ? cnt + 1'b1 : cnt;
      if (fifo_rd) begin
        m_data[idx*8 +: 8] <= fifo_data;
        idx                <= idx + 1'b1;
      end
      if (fifo_rd & (idx == LAST_LANE)) begin
        m_keep <= '1;
        m_last <= 1'b0;
      end else if (do_flush & has_bytes) begin
        m_keep <= part_keep;
        m_last <= 1'b1;
        idx    <= '0;
      end
      if (m_valid & m_ready) begin
        m_data <= '0;
        m_keep <= '0;
        m_last <= 1'b0;
      end
    end
endmodule

// File: doc/fifo_word_packer.md
Name: fifo_word_packer

Overview:
- Read-side consumer for the 8-bit FIFO memory unit. It drains bytes via the FIFO's rd/fifo_empty/data_out interface and packs them little-endian into BYTES-wide words.
- Words are presented to a downstream valid/ready sink.
- A partial word can be emitted by an explicit flush or by an optional idle timeout. Such a word carries a byte-keep mask and a last marker.

Parameters:
- BYTES, 4: bytes per output word; must be a power of two, 2 to 8.
- IDLE_TIMEOUT, 0: cycles without a capture, while a partial word is held, before an automatic flush. 0 disables the timeout.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- fifo_data  input  8  FIFO data_out; combinational read of the current read pointer.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd  output  1  read request to the FIFO rd input; the FIFO pops on the same edge.
- flush  input  1  single-cycle request to emit any partial word.
- m_data  output  8*BYTES  packed word; byte 0 is in bits [7:0].
- m_keep  output  BYTES  valid-byte mask for m_data.
- m_last  output  1  word was terminated by a flush or timeout.
- m_valid  output  1  output word valid.
- m_ready  input  1  downstream accept.
- busy  output  1  accumulator holds at least one byte, or a word is pending.

Behaviour:
- States are FILL and HOLD.
- Reset:
  - state goes to FILL; byte index, timeout counter and flush_pend go to 0.
  - m_data, m_keep, m_last, m_valid and busy are all 0.
  - fifo_rd is forced to 0 in any cycle where rst=1.
  - Reset mid-word or mid-HOLD discards the held data with no output.
- fifo_rd = (state==FILL) & ~fifo_empty & ~flush & ~flush_pend & ~timeout_hit & ~rst.
- Byte capture:
  - When fifo_rd=1, fifo_data is written to lane idx on that edge, and idx increments.
  - Bytes are never lost or duplicated: exactly one capture per FIFO pop.
- Full word:
  - When the capture is into lane BYTES-1, the next state is HOLD.
  - From the next cycle: m_valid=1, m_keep=all ones, m_last=0, idx=0.
  - Latency from the final byte's fifo_rd to m_valid is 1 cycle.
- HOLD:
  - m_data, m_keep and m_last are stable while m_valid=1 and m_ready=0.
  - When m_valid&m_ready, the next state is FILL and m_valid=0 on the next cycle.
  - fifo_rd=0 throughout HOLD, so maximum throughput is one word per BYTES+1 cycles.
- Flush in FILL (flush=1, or flush_pend=1):
  - If idx>0: go to HOLD with m_valid=1, m_keep=(1<<idx)-1, m_last=1, unused lanes zeroed; then idx=0.
  - If idx==0: no output; the flush completes silently.
  - flush_pend is cleared in either case.
  - No byte is read in the flush cycle, even if the FIFO is non-empty.
- Flush in HOLD:
  - Sets flush_pend, which is handled on the first FILL cycle.
  - idx is 0 at that point, so it completes silently.
  - flush never modifies a word already presented.
- Timeout (IDLE_TIMEOUT>0):
  - The counter increments each FILL cycle with idx>0 and no capture.
  - It clears on any capture, on entry to HOLD, and on reset.
  - timeout_hit = (count == IDLE_TIMEOUT-1) & idx>0 & no capture. It behaves exactly as a flush in that cycle.
  - The counter width is sized to IDLE_TIMEOUT; it never wraps.
- busy = (idx>0) | (state==HOLD).
- fifo_empty high for any duration simply stalls FILL; no timeout applies when idx==0.

Test Plan:
- Full word:
  - Stimulus: reset, then FIFO preloaded with 0x11,0x22,0x33,0x44 and m_ready=1.
  - Response: fifo_rd high 4 consecutive cycles; 1 cycle later m_valid=1, m_data=0x44332211, m_keep=4'hF, m_last=0; m_valid drops the cycle after acceptance.
- Backpressure:
  - Stimulus: 8 bytes 0x01..0x08 with m_ready=0 for 5 cycles after the first m_valid.
  - Response: m_data held at 0x04030201 with no fifo_rd during the hold; after release the second word is 0x08070605.
- Partial flush:
  - Stimulus: 3 bytes 0xAA,0xBB,0xCC, FIFO then empty, flush pulsed.
  - Response: next cycle m_data=0x00CCBBAA, m_keep=4'h7, m_last=1; a second flush with an empty accumulator produces no m_valid.
- Timeout:
  - Stimulus: IDLE_TIMEOUT=8, one byte 0x5A, FIFO stays empty.
  - Response: 8 cycles after the capture, m_valid=1, m_data=0x0000005A, m_keep=4'h1, m_last=1; a new byte arriving before cycle 8 restarts the count.
- Flush with non-empty FIFO:
  - Stimulus: 2 bytes captured, flush asserted while fifo_empty=0.
  - Response: fifo_rd=0 that cycle; partial word with keep 4'h3 and last=1; the remaining FIFO bytes start a new word after the handoff, none lost.
- Reset mid-word:
  - Stimulus: 2 bytes captured, then rst for 1 cycle.
  - Response: m_valid, busy and idx all 0, fifo_rd=0 during rst; the next 4 bytes form a clean full word.
